// File: rtl/enc_out_packer_pkg.sv
// Shared types and constants for the encrypt_pipe output packer.
// Holds the FSM state encoding and the lane-mask helper used when emitting partial words.
package enc_out_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } pack_state_t;

  localparam int WORD_BYTES = 4;

  // Mask keeping the lowest n byte lanes of a word; upper lanes are forced to zero.
  function automatic logic [31:0] keep_lanes(input logic [2:0] n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      m[8*i +: 8] = (i < int'(n)) ? 8'hFF : 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/enc_out_packer_byte_fifo.sv
// Byte FIFO with an extra pointer bit for full/empty and a combinational head read.
// A write while full is still accepted when a pop happens in the same cycle.
module byte_fifo #(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_push;
  logic        w_pop;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign level   = r_wr_ptr - r_rd_ptr;
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  assign w_pop  = rd_en && !empty;
  // When full, the slot being written is the head being popped this cycle.
  assign w_push = wr_en && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/enc_out_packer.sv
// Buffers the non-stalling encrypt_pipe byte stream and packs it little-endian into
// 32-bit words on a valid/ready output, with flush of partial words and sticky overflow.
module enc_out_packer
  import enc_out_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enc_v,
  input  logic [7:0]    enc_data,
  input  logic          flush,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [31:0]   word_data,
  output logic [2:0]    word_bytes,
  output logic          overflow,
  input  logic          clr_ovf,
  output logic [AW:0]   level
);

  pack_state_t r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_asm;
  logic [31:0] r_word_data;
  logic [2:0]  r_word_bytes;
  logic        r_word_valid;
  logic        r_overflow;
  logic        r_flush_pend;

  logic        w_empty;
  logic        w_full;
  logic [7:0]  w_rd_data;
  logic        w_pop;
  logic        w_drop;

  assign w_pop  = (r_state == COLLECT) && !w_empty;
  assign w_drop = enc_v && w_full && !w_pop;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (enc_v),
    .wr_data (enc_data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .level   (level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= COLLECT;
      r_cnt        <= '0;
      r_asm        <= '0;
      r_word_data  <= '0;
      r_word_bytes <= '0;
      r_word_valid <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (!w_empty) begin
            if (r_cnt == 3'(WORD_BYTES - 1)) begin
              r_word_data  <= {w_rd_data, r_asm[23:0]};
              r_word_bytes <= 3'(WORD_BYTES);
              r_word_valid <= 1'b1;
              r_cnt        <= '0;
              r_state      <= HOLD;
            end else begin
              r_asm[{r_cnt[1:0], 3'b000} +: 8] <= w_rd_data;
              r_cnt <= r_cnt + 3'd1;
            end
          end else if (r_flush_pend) begin
            if (r_cnt != 3'd0) begin
              r_word_data  <= r_asm & keep_lanes(r_cnt);
              r_word_bytes <= r_cnt;
              r_word_valid <= 1'b1;
              r_cnt        <= '0;
              r_state      <= HOLD;
            end
            r_flush_pend <= 1'b0;
          end
        end
        HOLD: begin
          if (word_ready) begin
            r_word_valid <= 1'b0;
            r_state      <= COLLECT;
          end
        end
        default: r_state <= COLLECT;
      endcase
      // A new pulse wins over the clear so a request is never lost.
      if (flush) r_flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign word_valid = r_word_valid;
  assign word_data  = r_word_data;
  assign word_bytes = r_word_bytes;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_enc_out_packer.sv
// Directed bench for enc_out_packer: a per-cycle vector table for basic packing and
// partial flush, then hand-written sequences for backpressure, overflow, full+pop and reset.
module tb_enc_out_packer;

  logic        clk;
  logic        rst;
  logic        enc_v;
  logic [7:0]  enc_data;
  logic        flush;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic [2:0]  word_bytes;
  logic        overflow;
  logic        clr_ovf;
  logic [4:0]  level;

  int total = 0;
  int bad   = 0;

  enc_out_packer #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .enc_v      (enc_v),
    .enc_data   (enc_data),
    .flush      (flush),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_bytes (word_bytes),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        fl;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [2:0]  exp_bytes;
    logic [4:0]  exp_level;
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!word_valid && n < max_cycles) begin
      step();
      n++;
    end
    total++;
    if (!word_valid) begin
      bad++;
      $display("FAIL %s: word_valid still 0 after %0d cycles, expected 1", name, max_cycles);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    enc_v    = 1'b1;
    enc_data = b;
    step();
    enc_v    = 1'b0;
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] exp_w;

    // per cycle: enc_v, enc_data, word_ready, flush -> valid, data, bytes, level after the edge
    vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 32'h00000000, 3'd0, 5'd1};
    vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 32'h00000000, 3'd0, 5'd1};
    vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 32'h00000000, 3'd0, 5'd1};
    vecs[3]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 32'h00000000, 3'd0, 5'd1};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h44332211, 3'd4, 5'd0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h44332211, 3'd4, 5'd0};
    vecs[6]  = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 32'h44332211, 3'd4, 5'd1};
    vecs[7]  = '{1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 32'h44332211, 3'd4, 5'd1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h44332211, 3'd4, 5'd0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000BBAA, 3'd2, 5'd0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0000BBAA, 3'd2, 5'd0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0000BBAA, 3'd2, 5'd0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0000BBAA, 3'd2, 5'd0};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0000BBAA, 3'd2, 5'd0};

    rst        = 1'b0;
    enc_v      = 1'b0;
    enc_data   = 8'h00;
    flush      = 1'b0;
    word_ready = 1'b0;
    clr_ovf    = 1'b0;
    step();
    step();
    chk("reset word_valid", 32'(word_valid), 32'd0);
    chk("reset level", 32'(level), 32'd0);
    chk("reset word_data", word_data, 32'h0);
    chk("reset word_bytes", 32'(word_bytes), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Basic pack and partial flush, cycle by cycle
    for (int i = 0; i < 14; i++) begin
      enc_v      = vecs[i].v;
      enc_data   = vecs[i].d;
      word_ready = vecs[i].rdy;
      flush      = vecs[i].fl;
      step();
      chk($sformatf("vec%0d word_valid", i), 32'(word_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d word_data", i), word_data, vecs[i].exp_data);
      chk($sformatf("vec%0d word_bytes", i), 32'(word_bytes), 32'(vecs[i].exp_bytes));
      chk($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].exp_level));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'd0);
      $display("vec %0d: v=%0d d=%h rdy=%0d fl=%0d -> valid=%0d data=%h bytes=%0d level=%0d",
               i, vecs[i].v, vecs[i].d, vecs[i].rdy, vecs[i].fl,
               word_valid, word_data, word_bytes, level);
    end
    enc_v = 1'b0;
    flush = 1'b0;

    // Backpressure: word holds for 10 cycles while the next word streams in
    word_ready = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    wait_valid("bp first word", 8);
    for (int i = 0; i < 10; i++) begin
      enc_v    = (i < 4);
      enc_data = 8'h55 + 8'(8'h11 * i);
      step();
      chk($sformatf("bp hold data c%0d", i), word_data, 32'h44332211);
      chk($sformatf("bp hold valid c%0d", i), 32'(word_valid), 32'd1);
    end
    enc_v = 1'b0;
    chk("bp level", 32'(level), 32'd4);
    $display("backpressure: held %h, level=%0d", word_data, level);
    word_ready = 1'b1;
    step();
    chk("bp transfer valid", 32'(word_valid), 32'd0);
    wait_valid("bp second word", 10);
    chk("bp second data", word_data, 32'h88776655);
    chk("bp second bytes", 32'(word_bytes), 32'd4);
    $display("backpressure: second word %h bytes=%0d", word_data, word_bytes);
    step();
    chk("bp consumed", 32'(word_valid), 32'd0);

    // Overflow: 22 bytes with the output stalled
    word_ready = 1'b0;
    chk("ovf pre", 32'(overflow), 32'd0);
    for (int i = 0; i < 22; i++) send_byte(8'(i));
    chk("ovf flag", 32'(overflow), 32'd1);
    chk("ovf level", 32'(level), 32'd16);
    $display("overflow: ovf=%0d level=%0d", overflow, level);
    word_ready = 1'b1;
    for (int w = 0; w < 5; w++) begin
      wait_valid($sformatf("ovf drain w%0d", w), 30);
      b = 8'(4 * w);
      exp_w = {b + 8'd3, b + 8'd2, b + 8'd1, b};
      chk($sformatf("ovf drain data w%0d", w), word_data, exp_w);
      $display("overflow drain word %0d: %h", w, word_data);
      step();
    end
    for (int i = 0; i < 8; i++) step();
    chk("ovf no sixth word", 32'(word_valid), 32'd0);
    chk("ovf drained level", 32'(level), 32'd0);
    chk("ovf still sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf cleared", 32'(overflow), 32'd0);

    // Full FIFO written in the same cycle as a pop
    word_ready = 1'b0;
    for (int i = 0; i < 20; i++) send_byte(8'hA0 + 8'(i));
    chk("fp level full", 32'(level), 32'd16);
    chk("fp no ovf", 32'(overflow), 32'd0);
    chk("fp hold data", word_data, 32'hA3A2A1A0);
    word_ready = 1'b1;
    step();
    chk("fp transfer valid", 32'(word_valid), 32'd0);
    chk("fp level after transfer", 32'(level), 32'd16);
    enc_v    = 1'b1;
    enc_data = 8'hC0;
    flush    = 1'b1;
    step();
    enc_v = 1'b0;
    flush = 1'b0;
    chk("fp level push+pop", 32'(level), 32'd16);
    chk("fp ovf push+pop", 32'(overflow), 32'd0);
    $display("full+pop: level=%0d ovf=%0d", level, overflow);
    for (int w = 0; w < 4; w++) begin
      wait_valid($sformatf("fp drain w%0d", w), 30);
      b = 8'hA4 + 8'(4 * w);
      exp_w = {b + 8'd3, b + 8'd2, b + 8'd1, b};
      chk($sformatf("fp drain data w%0d", w), word_data, exp_w);
      $display("full+pop drain word %0d: %h", w, word_data);
      step();
    end
    wait_valid("fp tail", 10);
    chk("fp tail data", word_data, 32'h000000C0);
    chk("fp tail bytes", 32'(word_bytes), 32'd1);
    $display("full+pop tail: %h bytes=%0d", word_data, word_bytes);
    step();
    chk("fp tail consumed", 32'(word_valid), 32'd0);

    // Asynchronous reset in HOLD with 9 bytes buffered
    word_ready = 1'b0;
    for (int i = 0; i < 13; i++) send_byte(8'h30 + 8'(i));
    chk("ar pre valid", 32'(word_valid), 32'd1);
    chk("ar pre level", 32'(level), 32'd9);
    #2;
    rst = 1'b0;
    #1;
    chk("ar valid low", 32'(word_valid), 32'd0);
    chk("ar level zero", 32'(level), 32'd0);
    $display("async reset: valid=%0d level=%0d", word_valid, level);
    step();
    @(negedge clk);
    rst = 1'b1;
    word_ready = 1'b1;
    step();
    send_byte(8'h5A);
    send_byte(8'h6B);
    send_byte(8'h7C);
    send_byte(8'h8D);
    wait_valid("ar word", 10);
    chk("ar word data", word_data, 32'h8D7C6B5A);
    chk("ar word bytes", 32'(word_bytes), 32'd4);
    $display("after reset: word %h bytes=%0d", word_data, word_bytes);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enc_out_packer.md
Name: enc_out_packer

Overview:
Downstream stage of encrypt_pipe. Consumes its byte stream (v, dout), which never stalls, and buffers it in a byte FIFO. Packs the bytes little-endian into 32-bit words and presents them on a valid/ready interface to the host or output bus. Supports flushing a partial word and reports dropped bytes with a sticky overflow flag.

Parameters:
DEPTH, 16, byte FIFO entries; power of two, minimum 4
AW, $clog2(DEPTH), derived FIFO pointer width; not overridden

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
enc_v  in  1  byte valid, driven from encrypt_pipe v
enc_data  in  8  byte, driven from encrypt_pipe dout
flush  in  1  single-cycle pulse: emit any partial word once the FIFO drains
word_valid  out  1  output word available
word_ready  in  1  consumer accepts word
word_data  out  32  packed word; first byte in [7:0]
word_bytes  out  3  number of valid bytes in word_data (1..4)
overflow  out  1  sticky: a byte was dropped
clr_ovf  in  1  clears overflow
level  out  AW+1  current FIFO occupancy (0..DEPTH)

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, level=0, state COLLECT, assembly count=0, word_valid=0, word_data=0, word_bytes=0, overflow=0, flush_pend=0.
- FIFO write:
  - A byte is accepted when enc_v=1 and (not full, or a pop occurs in the same cycle).
  - If enc_v=1 while full and there is no pop, the byte is dropped and overflow is set.
  - There is no backpressure to encrypt_pipe.
- Overflow flag: set has priority over clr_ovf in the same cycle.
- FSM states: COLLECT and HOLD.
- COLLECT:
  - If the FIFO is non-empty, pop one byte per cycle into byte lane cnt of the assembly register; cnt increments.
  - The pop that makes cnt reach 4 also loads the output register: word_data = assembly, word_bytes=4, cnt cleared, next state HOLD.
  - If the FIFO is empty, flush_pend=1 and cnt>0: load the output register with the unused upper lanes zeroed, word_bytes=cnt, cnt cleared, flush_pend cleared, next state HOLD.
  - If the FIFO is empty, flush_pend=1 and cnt=0: clear flush_pend; no word is emitted.
- HOLD:
  - word_valid=1. word_data and word_bytes hold stable until word_valid and word_ready are both 1.
  - On transfer, go to COLLECT.
  - No FIFO pops occur in HOLD; the FIFO keeps filling.
- Flush:
  - A flush pulse sets flush_pend in any state.
  - Bytes written after the flush pulse but before the FIFO drains are included in the flushed data.
  - A flush while flush_pend=1 has no additional effect.
- Latency: bytes presented in cycles t..t+3 with an empty FIFO and state COLLECT give word_valid=1 in cycle t+5. Sustained throughput is 4 bytes per 5 cycles when word_ready=1, so encrypt_pipe bursts beyond the FIFO slack overflow by design.
- Capacity: with word_ready held low, DEPTH+4 bytes are stored (the assembly register holds the next word after HOLD). Byte DEPTH+5 onwards is dropped.
- Pointers wrap modulo DEPTH. Full/empty are distinguished with an extra pointer bit, and level = wr_ptr - rd_ptr.
- Reset mid-operation: word_valid deasserts immediately and all buffered bytes are discarded.

Decomposition:
- Package enc_out_pkg: typedef enum logic {COLLECT, HOLD} pack_state_t; localparam WORD_BYTES=4.
- Sub-module byte_fifo (parameter DEPTH):
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data (combinational read of head), full, empty, level.
  - The same-cycle write-when-full-with-pop rule lives in this sub-module.
- The FSM, assembly register and overflow flag live in enc_out_packer.

Test Plan:
- Basic pack: word_ready=1; enc_data 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles from t -> word_valid in cycle t+5, word_data=32'h44332211, word_bytes=4, level back to 0.
- Backpressure: word_ready=0 for 10 cycles after word_valid rises, with 4 more bytes 8'h55..8'h88 streamed meanwhile -> word_data stays 32'h44332211. After word_ready=1, the next word is 32'h88776655.
- Partial flush: bytes 8'hAA, 8'hBB then a flush pulse -> one word 32'h0000BBAA with word_bytes=2. A second flush with an empty FIFO and cnt=0 -> no word_valid.
- Overflow: DEPTH=16, word_ready=0, 22 consecutive bytes 8'h00..8'h15 -> overflow=1 and level=16. Draining yields 5 words ending 32'h13121110; bytes 8'h14 and 8'h15 are absent. clr_ovf -> overflow=0.
- Simultaneous full write and pop: FIFO full, enc_v=1 in the same cycle as a COLLECT pop -> byte accepted, level stays 16, overflow stays 0.
- Async reset: drive rst=0 mid-cycle while in HOLD with level=9 -> word_valid=0 and level=0 before the next clk edge. After release, the first 4 bytes produce a correct word.
